// File: rtl/multi_port_fifo_pkg.sv
// Shared configuration for multi_port_fifo: default geometry, lane-width
// helpers and the modulo-ELEMENTS pointer add used by mpfifo_ptr_add.
package multi_port_fifo_pkg;

  localparam int unsigned MPF_DATA_WIDTH = 8;
  localparam int unsigned MPF_ELEMENTS   = 16;
  localparam int unsigned MPF_PUSH_W     = 4;
  localparam int unsigned MPF_POP_W      = 3;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned elements);
    return (elements > 1) ? $clog2(elements) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Widths for the default geometry.
  localparam int unsigned CNT_W = cnt_width(max_u(MPF_PUSH_W, MPF_POP_W));
  localparam int unsigned OCC_W = cnt_width(MPF_ELEMENTS);
  localparam int unsigned PTR_W = ptr_width(MPF_ELEMENTS);

  // Compare/subtract wrap so non-power-of-two depths work; cnt never exceeds elements.
  function automatic int unsigned mod_add(input int unsigned ptr, input int unsigned cnt,
                                          input int unsigned elements);
    int unsigned sum;
    sum = ptr + cnt;
    return (sum >= elements) ? sum - elements : sum;
  endfunction

endpackage

// File: rtl/multi_port_fifo_if.sv
// Push/pop bus of multi_port_fifo. The flush signal exists only when
// MPFIFO_FLUSH_EN is defined.
interface multi_port_fifo_if
  import multi_port_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MPF_DATA_WIDTH,
  parameter int unsigned ELEMENTS   = MPF_ELEMENTS,
  parameter int unsigned PUSH_W     = MPF_PUSH_W,
  parameter int unsigned POP_W      = MPF_POP_W
) ();

  localparam int unsigned PUSH_CNT_BITS = cnt_width(PUSH_W);
  localparam int unsigned POP_CNT_BITS  = cnt_width(POP_W);
  localparam int unsigned OCC_BITS      = cnt_width(ELEMENTS);

  // Handshake: a push group is taken whole on a clock edge where din_ready=1
  // (din_count <= din_free); the pop side may take up to dout_count entries per edge.
  logic [PUSH_W*DATA_WIDTH-1:0] din;
  logic [PUSH_CNT_BITS-1:0]     din_count;
  logic [OCC_BITS-1:0]          din_free;
  logic                         din_ready;
  logic [POP_W*DATA_WIDTH-1:0]  dout;
  logic [POP_CNT_BITS-1:0]      dout_count;
  logic [POP_CNT_BITS-1:0]      dout_take;
  logic [OCC_BITS-1:0]          occupancy;
`ifdef MPFIFO_FLUSH_EN
  logic                         flush;

  modport master (
    output din, din_count, dout_take, flush,
    input  din_free, din_ready, dout, dout_count, occupancy
  );
  modport slave (
    input  din, din_count, dout_take, flush,
    output din_free, din_ready, dout, dout_count, occupancy
  );
`else
  modport master (
    output din, din_count, dout_take,
    input  din_free, din_ready, dout, dout_count, occupancy
  );
  modport slave (
    input  din, din_count, dout_take,
    output din_free, din_ready, dout, dout_count, occupancy
  );
`endif

endinterface

// File: rtl/multi_port_fifo_ptr_add.sv
// mpfifo_ptr_add: ring pointer plus a small count, wrapped modulo ELEMENTS.
module mpfifo_ptr_add
  import multi_port_fifo_pkg::*;
#(
  parameter int unsigned ELEMENTS = MPF_ELEMENTS,
  parameter int unsigned PTR_BITS = PTR_W,
  parameter int unsigned ADD_BITS = CNT_W
) (
  input  logic [PTR_BITS-1:0] ptr_i,
  input  logic [ADD_BITS-1:0] cnt_i,
  output logic [PTR_BITS-1:0] sum_o
);

  assign sum_o = PTR_BITS'(mod_add(32'(ptr_i), 32'(cnt_i), ELEMENTS));

endmodule

// File: rtl/multi_port_fifo.sv
// Circular FIFO taking up to PUSH_W entries and releasing up to POP_W per cycle.
// Optional flush port enabled by MPFIFO_FLUSH_EN.
module multi_port_fifo
  import multi_port_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MPF_DATA_WIDTH,
  parameter int unsigned ELEMENTS   = MPF_ELEMENTS,
  parameter int unsigned PUSH_W     = MPF_PUSH_W,
  parameter int unsigned POP_W      = MPF_POP_W
) (
  input logic              clk,
  input logic              rst,
  multi_port_fifo_if.slave bus
);

  localparam int unsigned PTR_BITS      = ptr_width(ELEMENTS);
  localparam int unsigned OCC_BITS      = cnt_width(ELEMENTS);
  localparam int unsigned PUSH_CNT_BITS = cnt_width(PUSH_W);
  localparam int unsigned POP_CNT_BITS  = cnt_width(POP_W);
  localparam int unsigned ADD_BITS      = cnt_width(max_u(PUSH_W, POP_W));

  logic [DATA_WIDTH-1:0]    mem_q [ELEMENTS];
  logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OCC_BITS-1:0]      occ_q, occ_d;

  logic [PTR_BITS-1:0]      waddr [PUSH_W];
  logic [PTR_BITS-1:0]      raddr [POP_W];
  logic [PTR_BITS-1:0]      wr_ptr_adv, rd_ptr_adv;
  logic [OCC_BITS-1:0]      free;
  logic                     ready;
  logic [PUSH_CNT_BITS-1:0] push_n;
  logic [POP_CNT_BITS-1:0]  avail;
  logic [POP_CNT_BITS-1:0]  pop_n;
  logic                     flush_act;
  logic                     wr_en;

`ifdef MPFIFO_FLUSH_EN
  assign flush_act = bus.flush;
`else
  assign flush_act = 1'b0;
`endif

  for (genvar i = 0; i < PUSH_W; i++) begin : g_waddr
    mpfifo_ptr_add #(.ELEMENTS(ELEMENTS), .PTR_BITS(PTR_BITS), .ADD_BITS(ADD_BITS)) u_add (
      .ptr_i (wr_ptr_q),
      .cnt_i (ADD_BITS'(i)),
      .sum_o (waddr[i])
    );
  end

  for (genvar j = 0; j < POP_W; j++) begin : g_raddr
    mpfifo_ptr_add #(.ELEMENTS(ELEMENTS), .PTR_BITS(PTR_BITS), .ADD_BITS(ADD_BITS)) u_add (
      .ptr_i (rd_ptr_q),
      .cnt_i (ADD_BITS'(j)),
      .sum_o (raddr[j])
    );
    assign bus.dout[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[j]];
  end

  mpfifo_ptr_add #(.ELEMENTS(ELEMENTS), .PTR_BITS(PTR_BITS), .ADD_BITS(ADD_BITS)) u_wr_adv (
    .ptr_i (wr_ptr_q),
    .cnt_i (ADD_BITS'(push_n)),
    .sum_o (wr_ptr_adv)
  );

  mpfifo_ptr_add #(.ELEMENTS(ELEMENTS), .PTR_BITS(PTR_BITS), .ADD_BITS(ADD_BITS)) u_rd_adv (
    .ptr_i (rd_ptr_q),
    .cnt_i (ADD_BITS'(pop_n)),
    .sum_o (rd_ptr_adv)
  );

  // Acceptance looks only at registered occupancy, so space freed by a pop shows up next cycle.
  assign free   = OCC_BITS'(ELEMENTS) - occ_q;
  assign ready  = OCC_BITS'(bus.din_count) <= free;
  assign push_n = ready ? bus.din_count : '0;
  assign avail  = (occ_q >= OCC_BITS'(POP_W)) ? POP_CNT_BITS'(POP_W) : POP_CNT_BITS'(occ_q);
  assign pop_n  = (bus.dout_take < avail) ? bus.dout_take : avail;
  assign wr_en  = ready && !flush_act && !rst;

  assign bus.din_free   = free;
  assign bus.din_ready  = ready;
  assign bus.dout_count = avail;
  assign bus.occupancy  = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_adv;
    rd_ptr_d = rd_ptr_adv;
    occ_d    = occ_q + OCC_BITS'(push_n) - OCC_BITS'(pop_n);
    if (flush_act) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (wr_en && (PUSH_CNT_BITS'(i) < bus.din_count)) begin
        mem_q[waddr[i]] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo (DATA_WIDTH=8, ELEMENTS=16, PUSH_W=4, POP_W=3).
module tb_multi_port_fifo;
  import multi_port_fifo_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  multi_port_fifo_if #(.DATA_WIDTH(8), .ELEMENTS(16), .PUSH_W(4), .POP_W(3)) bus ();

  multi_port_fifo #(.DATA_WIDTH(8), .ELEMENTS(16), .PUSH_W(4), .POP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int j);
    return bus.dout[j*8 +: 8];
  endfunction

  task automatic push(input logic [31:0] data, input int cnt);
    bus.din       = data;
    bus.din_count = CNT_W'(cnt);
  endtask

  task automatic idle();
    bus.din       = '0;
    bus.din_count = '0;
    bus.dout_take = '0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    idle();
`ifdef MPFIFO_FLUSH_EN
    bus.flush = 1'b0;
`endif
    cyc();
    cyc();
    rst = 1'b0;
    #1;

    // 1. reset state
    check("rst_dout_count", 32'(bus.dout_count), 32'd0);
    check("rst_din_free",   32'(bus.din_free),   32'd16);
    check("rst_occupancy",  32'(bus.occupancy),  32'd0);
    bus.din_count = 3'd1;
    #1;
    check("rst_ready_cnt1", 32'(bus.din_ready), 32'd1);

    // 2. first group; nothing visible before the edge
    push(32'hA3A2A1A0, 4);
    #1;
    check("no_bypass_count", 32'(bus.dout_count), 32'd0);
    cyc();
    idle();
    #1;
    check("p1_lane0", 32'(lane(0)), 32'hA0);
    check("p1_lane1", 32'(lane(1)), 32'hA1);
    check("p1_lane2", 32'(lane(2)), 32'hA2);
    check("p1_dout_count", 32'(bus.dout_count), 32'd3);
    check("p1_occupancy",  32'(bus.occupancy),  32'd4);
    check("p1_din_free",   32'(bus.din_free),   32'd12);

    // 3. fill to 14, refuse 3, accept 2
    push(32'hB3B2B1B0, 4); cyc();
    push(32'hC3C2C1C0, 4); cyc();
    push(32'h0000D1D0, 2); cyc();
    idle();
    #1;
    check("fill14_occ",  32'(bus.occupancy), 32'd14);
    check("fill14_free", 32'(bus.din_free),  32'd2);
    push(32'h00111111, 3);
    #1;
    check("over3_ready", 32'(bus.din_ready), 32'd0);
    cyc();
    check("over3_occ", 32'(bus.occupancy), 32'd14);
    push(32'h0000E1E0, 2);
    #1;
    check("exact2_ready", 32'(bus.din_ready), 32'd1);
    cyc();
    idle();
    #1;
    check("full_occ",        32'(bus.occupancy),  32'd16);
    check("full_free",       32'(bus.din_free),   32'd0);
    check("full_dout_count", 32'(bus.dout_count), 32'd3);
    check("full_lane0",      32'(lane(0)),        32'hA0);
    check("full_ready_cnt0", 32'(bus.din_ready),  32'd1);

    // 4. full: push refused even with a same-cycle pop
    push(32'h00000099, 1);
    bus.dout_take = 2'd3;
    #1;
    check("full_push_ready", 32'(bus.din_ready), 32'd0);
    cyc();
    check("full_pop_occ", 32'(bus.occupancy), 32'd13);
    check("full_pop_lane0", 32'(lane(0)), 32'hA3);
    check("full_pop_lane1", 32'(lane(1)), 32'hB0);
    check("full_pop_lane2", 32'(lane(2)), 32'hB1);
    push(32'h00F2F1F0, 3);
    bus.dout_take = 2'd3;
    #1;
    check("push_pop_ready", 32'(bus.din_ready), 32'd1);
    cyc();
    idle();
    #1;
    check("push_pop_occ",   32'(bus.occupancy), 32'd13);
    check("push_pop_lane0", 32'(lane(0)), 32'hB2);
    check("push_pop_lane1", 32'(lane(1)), 32'hB3);
    check("push_pop_lane2", 32'(lane(2)), 32'hC0);

    // drain 12 of 13; last entry is F2
    bus.dout_take = 2'd3;
    for (int k = 0; k < 4; k++) cyc();
    bus.dout_take = 2'd0;
    #1;
    check("drain_occ",   32'(bus.occupancy),  32'd1);
    check("drain_count", 32'(bus.dout_count), 32'd1);
    check("drain_lane0", 32'(lane(0)), 32'hF2);

    // 6a. take beyond dout_count is clamped
    bus.dout_take = 2'd3;
    cyc();
    idle();
    #1;
    check("clamp_occ",  32'(bus.occupancy), 32'd0);
    check("clamp_free", 32'(bus.din_free),  32'd16);

    // 5. walk both pointers from 3 to 14, then wrap a group across the end
    push(32'h33323130, 4); cyc();
    push(32'h37363534, 4); cyc();
    push(32'h003A3938, 3); cyc();
    idle();
    bus.dout_take = 2'd3;
    cyc(); cyc(); cyc();
    bus.dout_take = 2'd2;
    cyc();
    idle();
    #1;
    check("walk_occ", 32'(bus.occupancy), 32'd0);
    push(32'h63626160, 4);
    cyc();
    idle();
    #1;
    check("wrap_lane0", 32'(lane(0)), 32'h60);
    check("wrap_lane1", 32'(lane(1)), 32'h61);
    check("wrap_lane2", 32'(lane(2)), 32'h62);
    check("wrap_count", 32'(bus.dout_count), 32'd3);
    bus.dout_take = 2'd3;
    cyc();
    bus.dout_take = 2'd0;
    #1;
    check("wrap_tail_lane0", 32'(lane(0)), 32'h63);
    check("wrap_tail_count", 32'(bus.dout_count), 32'd1);
    bus.dout_take = 2'd1;
    cyc();
    idle();
    #1;
    check("wrap_empty_occ", 32'(bus.occupancy), 32'd0);

    // 6b. single entry, clamped take
    push(32'h00000077, 1);
    cyc();
    idle();
    #1;
    check("single_count", 32'(bus.dout_count), 32'd1);
    check("single_lane0", 32'(lane(0)), 32'h77);
    bus.dout_take = 2'd3;
    cyc();
    idle();
    #1;
    check("single_occ", 32'(bus.occupancy), 32'd0);

`ifdef MPFIFO_FLUSH_EN
    push(32'h83828180, 4);
    cyc();
    push(32'h87868584, 4);
    bus.dout_take = 2'd2;
    bus.flush     = 1'b1;
    cyc();
    bus.flush = 1'b0;
    idle();
    #1;
    check("flush_occ",   32'(bus.occupancy),  32'd0);
    check("flush_count", 32'(bus.dout_count), 32'd0);
    check("flush_free",  32'(bus.din_free),   32'd16);
    push(32'h00000090, 1);
    cyc();
    idle();
    #1;
    check("post_flush_lane0", 32'(lane(0)), 32'h90);
    check("post_flush_occ",   32'(bus.occupancy), 32'd1);
`endif

    // reset mid-stream with traffic on both sides
    push(32'h4B4A4948, 4);
    cyc();
    push(32'h4F4E4D4C, 4);
    bus.dout_take = 2'd3;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    #1;
    check("midrst_occ",   32'(bus.occupancy),  32'd0);
    check("midrst_free",  32'(bus.din_free),   32'd16);
    check("midrst_count", 32'(bus.dout_count), 32'd0);
    check("midrst_ready", 32'(bus.din_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
